// File: rtl/aurva_counter_bank.sv
//------------------------------------------------------------------------------
// aurva_counter_bank : bank of independent up/down counters, shared step,
//                      wrap or saturate overflow, fully registered outputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aurva_counter_bank #(
    parameter int                  C_CHANNELS = 4,
    parameter int                  C_WIDTH    = 16,
    parameter logic [C_WIDTH-1:0]  C_INIT     = '0,
    parameter bit                  C_SATURATE = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clken,
    input  logic [C_CHANNELS-1:0]           load,
    input  logic [C_CHANNELS-1:0]           incr,
    input  logic [C_CHANNELS-1:0]           decr,
    input  logic [C_CHANNELS*C_WIDTH-1:0]   load_value,
    input  logic [C_WIDTH-1:0]              step,
    output logic [C_CHANNELS*C_WIDTH-1:0]   count,
    output logic [C_CHANNELS-1:0]           is_zero,
    output logic [C_CHANNELS-1:0]           is_max,
    output logic [C_CHANNELS-1:0]           ovf,
    output logic [C_CHANNELS-1:0]           unf
);

    localparam logic [C_WIDTH-1:0] C_MAX       = '1;
    localparam logic               C_INIT_ZERO = (C_INIT == '0);
    localparam logic               C_INIT_MAX  = (C_INIT == C_MAX);

    for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_ch
        logic [C_WIDTH-1:0] cnt_q  = C_INIT;
        logic               zero_q = C_INIT_ZERO;
        logic               max_q  = C_INIT_MAX;
        logic               ovf_q  = 1'b0;
        logic               unf_q  = 1'b0;

        logic [C_WIDTH-1:0] cnt_d;
        logic               ovf_d;
        logic               unf_d;
        logic [C_WIDTH:0]   sum;
        logic [C_WIDTH:0]   diff;

        // One extra bit holds the carry of the add and the borrow of the subtract.
        assign sum  = {1'b0, cnt_q} + {1'b0, step};
        assign diff = {1'b0, cnt_q} - {1'b0, step};

        always_comb begin
            cnt_d = cnt_q;
            ovf_d = 1'b0;
            unf_d = 1'b0;
            if (clken) begin
                if (load[gi]) begin
                    cnt_d = load_value[gi*C_WIDTH +: C_WIDTH];
                end else if (incr[gi] && !decr[gi]) begin
                    ovf_d = sum[C_WIDTH];
                    cnt_d = (C_SATURATE && sum[C_WIDTH]) ? C_MAX : sum[C_WIDTH-1:0];
                end else if (decr[gi] && !incr[gi]) begin
                    unf_d = diff[C_WIDTH];
                    cnt_d = (C_SATURATE && diff[C_WIDTH]) ? '0 : diff[C_WIDTH-1:0];
                end
            end
        end

        // Flags come from the next count so they never lag the count by a cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= C_INIT;
                zero_q <= C_INIT_ZERO;
                max_q  <= C_INIT_MAX;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                zero_q <= (cnt_d == '0);
                max_q  <= (cnt_d == C_MAX);
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end

        assign count[gi*C_WIDTH +: C_WIDTH] = cnt_q;
        assign is_zero[gi]                  = zero_q;
        assign is_max[gi]                   = max_q;
        assign ovf[gi]                      = ovf_q;
        assign unf[gi]                      = unf_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_aurva_counter_bank.sv
//------------------------------------------------------------------------------
// tb_aurva_counter_bank : scoreboard bench for a wrap and a saturate instance.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aurva_counter_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b0;
    logic [3:0]  load = '0, incr = '0, decr = '0;
    logic [15:0] load_value = '0;
    logic [3:0]  step = '0;

    logic [15:0] count_w, count_s;
    logic [3:0]  is_zero_w, is_max_w, ovf_w, unf_w;
    logic [3:0]  is_zero_s, is_max_s, ovf_s, unf_s;

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 1'b1;

    always #5 clk = ~clk;

    aurva_counter_bank #(.C_CHANNELS(4), .C_WIDTH(4), .C_INIT(4'h3), .C_SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .load_value(load_value), .step(step), .count(count_w), .is_zero(is_zero_w),
        .is_max(is_max_w), .ovf(ovf_w), .unf(unf_w)
    );

    aurva_counter_bank #(.C_CHANNELS(4), .C_WIDTH(4), .C_INIT(4'h3), .C_SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .load_value(load_value), .step(step), .count(count_s), .is_zero(is_zero_s),
        .is_max(is_max_s), .ovf(ovf_s), .unf(unf_s)
    );

    typedef struct {
        logic [15:0] cw, cs;
        logic [3:0]  zw, mw, ow, uw, zs, ms, os, us;
    } exp_t;

    exp_t q[$];
    int   m_w[4] = '{3, 3, 3, 3};
    int   m_s[4] = '{3, 3, 3, 3};

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Counter behaviour as plain integer arithmetic on a 0..15 range.
    function automatic void upd(inout int c, input bit sat, input bit r, input bit ce,
                                input bit ld, input bit inc, input bit dec,
                                input int lv, input int st, output bit ov, output bit un);
        int v;
        ov = 1'b0;
        un = 1'b0;
        if (r) begin
            c = 3;
        end else if (ce) begin
            if (ld) begin
                c = lv;
            end else if (inc && !dec) begin
                v = c + st;
                if (v > 15) begin
                    ov = 1'b1;
                    c  = sat ? 15 : v - 16;
                end else c = v;
            end else if (dec && !inc) begin
                v = c - st;
                if (v < 0) begin
                    un = 1'b1;
                    c  = sat ? 0 : v + 16;
                end else c = v;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (run) begin
            exp_t e;
            bit ov, un;
            for (int i = 0; i < 4; i++) begin
                upd(m_w[i], 1'b0, rst, clken, load[i], incr[i], decr[i],
                    int'(load_value[i*4 +: 4]), int'(step), ov, un);
                e.ow[i] = ov;
                e.uw[i] = un;
                upd(m_s[i], 1'b1, rst, clken, load[i], incr[i], decr[i],
                    int'(load_value[i*4 +: 4]), int'(step), ov, un);
                e.os[i] = ov;
                e.us[i] = un;
                e.cw[i*4 +: 4] = 4'(m_w[i]);
                e.cs[i*4 +: 4] = 4'(m_s[i]);
                e.zw[i] = (m_w[i] == 0);
                e.mw[i] = (m_w[i] == 15);
                e.zs[i] = (m_s[i] == 0);
                e.ms[i] = (m_s[i] == 15);
            end
            q.push_back(e);
        end
    end

    always @(posedge clk) begin
        #1;
        if (run) begin
            if (q.size() == 0) begin
                cmp("scoreboard_empty", 16'd0, 16'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                cmp("wrap_count", count_w, e.cw);
                cmp("wrap_is_zero", {12'd0, is_zero_w}, {12'd0, e.zw});
                cmp("wrap_is_max", {12'd0, is_max_w}, {12'd0, e.mw});
                cmp("wrap_ovf", {12'd0, ovf_w}, {12'd0, e.ow});
                cmp("wrap_unf", {12'd0, unf_w}, {12'd0, e.uw});
                cmp("sat_count", count_s, e.cs);
                cmp("sat_is_zero", {12'd0, is_zero_s}, {12'd0, e.zs});
                cmp("sat_is_max", {12'd0, is_max_s}, {12'd0, e.ms});
                cmp("sat_ovf", {12'd0, ovf_s}, {12'd0, e.os});
                cmp("sat_unf", {12'd0, unf_s}, {12'd0, e.us});
            end
        end
    end

    task automatic drive(input bit r, input bit ce, input logic [3:0] ld, input logic [3:0] inc,
                         input logic [3:0] dec, input logic [15:0] lv, input logic [3:0] st);
        @(negedge clk);
        rst        = r;
        clken      = ce;
        load       = ld;
        incr       = inc;
        decr       = dec;
        load_value = lv;
        step       = st;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1;
        cmp("powerup_count", count_w, 16'h3333);
        cmp("powerup_flags", {4'd0, is_zero_w, is_max_w, ovf_w}, 16'h0000);

        drive(1'b1, 1'b1, 4'h0, 4'hF, 4'h0, 16'h0, 4'h1);
        cmp("reset_count", count_w, 16'h3333);
        cmp("reset_flags", {is_zero_w, is_max_w, ovf_w, unf_w}, 16'h0000);

        drive(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 16'h502E, 4'h0);
        drive(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 16'h0, 4'h3);
        cmp("wrap_incr_count0", {12'd0, count_w[3:0]}, 16'h1);
        cmp("wrap_incr_ovf", {12'd0, ovf_w}, 16'h1);
        cmp("wrap_incr_ismax", {12'd0, is_max_w}, 16'h0);
        cmp("sat_incr_count0", {12'd0, count_s[3:0]}, 16'hF);
        drive(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 16'h0, 4'h3);
        cmp("wrap_incr2_count0", {12'd0, count_w[3:0]}, 16'h4);
        cmp("wrap_incr2_ovf", {12'd0, ovf_w}, 16'h0);

        drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h2, 16'h0, 4'h5);
        cmp("sat_decr_count1", {12'd0, count_s[7:4]}, 16'h0);
        cmp("sat_decr_unf", {12'd0, unf_s}, 16'h2);
        cmp("sat_decr_iszero1", {15'd0, is_zero_s[1]}, 16'h1);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h2, 16'h0, 4'h5);
        cmp("sat_decr_again_unf", {12'd0, unf_s}, 16'h2);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h2, 16'h0, 4'h0);
        cmp("sat_step0_unf", {12'd0, unf_s}, 16'h0);

        drive(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 16'h0007, 4'h1);
        cmp("prio_load_count0", {12'd0, count_w[3:0]}, 16'h7);
        drive(1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 16'h0, 4'h1);
        cmp("prio_both_hold", {12'd0, count_w[3:0]}, 16'h7);
        drive(1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 16'h0, 4'h1);
        cmp("prio_clken_hold", {12'd0, count_w[3:0]}, 16'h7);
        cmp("prio_clken_ovf", {12'd0, ovf_w}, 16'h0);

        drive(1'b0, 1'b1, 4'h0, 4'h1, 4'h4, 16'h0, 4'h1);
        cmp("indep_count", count_w, 16'h5F88);
        cmp("indep_unf", {12'd0, unf_w}, 16'h4);

        drive(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 16'h0, 4'h1);
        drive(1'b1, 1'b1, 4'h0, 4'h1, 4'h0, 16'h0, 4'h1);
        cmp("midrst_count0", {12'd0, count_w[3:0]}, 16'h3);
        drive(1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 16'h0, 4'h1);
        cmp("midrst_resume_count0", {12'd0, count_w[3:0]}, 16'h4);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0),
                  4'($urandom & $urandom & $urandom), 4'($urandom), 4'($urandom),
                  16'($urandom), st);
        end

        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0, 4'h0);
        run = 1'b0;
        cmp("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
